// File: rtl/spram_byte_arbiter.sv
// spram_byte_arbiter
//   Shares one byte-wide single-port RAM between NUM_PORTS requesters using
//   round-robin arbitration with an optional per-port burst lock. At most one
//   memory access is issued per cycle. Read data (1-cycle memory latency) is
//   routed back to the port that issued the read.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   req/lock/we       per-port request, burst hold, write(1)/read(0)
//   addr/wdata        per-port address and write data, port i at [i*W +: W]
//   gnt               one-hot accept strobe (request consumed this cycle)
//   rd_valid/rd_data  one-hot read-return strobe and shared read data
//   mem_*             SPRAM port (cs, write enable, address, wdata, rdata)
module spram_byte_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        lock,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        mem_cs,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned PW = $clog2(NUM_PORTS);
    localparam int unsigned CW = 8;

    typedef enum logic {FREE, OWNED} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tag_vld_q;
    logic [PW-1:0]     tag_port_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              gnt_any;
    logic              grant;
    logic [PW-1:0]     gnt_idx;
    logic              use_rr;
    logic              excl_active;
    logic [NUM_PORTS-1:0] excl;
    logic [NUM_PORTS-1:0] cand;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic              we_sel;
    int unsigned       scan_idx;

    // Arbitration: owner regrant while locked, otherwise round-robin from ptr.
    // On forced rotation the owner is masked for one cycle, but still wins if
    // nobody else is asking, which starts a fresh burst.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_any     = 1'b0;
        gnt_idx     = '0;
        use_rr      = 1'b0;
        excl_active = 1'b0;
        excl        = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        scan_idx    = 0;

        if (state_q == OWNED) begin
            if (!lock[owner_q]) begin
                use_rr  = 1'b1;
            end else if (cnt_q >= CW'(MAX_BURST)) begin
                use_rr         = 1'b1;
                excl_active    = 1'b1;
                excl[owner_q]  = 1'b1;
            end else if (req[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            use_rr = 1'b1;
        end

        cand = req & ~excl;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            scan_idx = (32'(ptr_q) + k) % NUM_PORTS;
            if (!pick_found && cand[scan_idx[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[PW-1:0];
            end
        end

        if (use_rr) begin
            state_d = FREE;
            cnt_d   = '0;
            if (pick_found) begin
                gnt_any = 1'b1;
                gnt_idx = pick_idx;
            end else if (excl_active && req[owner_q]) begin
                gnt_any = 1'b1;
                gnt_idx = owner_q;
            end
            if (gnt_any) begin
                ptr_d = (32'(gnt_idx) + 1 == NUM_PORTS) ? '0 : gnt_idx + PW'(1);
                if (lock[gnt_idx]) begin
                    state_d = OWNED;
                    owner_d = gnt_idx;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    assign grant = gnt_any & ~rst;

    // Memory-side mux and one-hot strobes
    always_comb begin
        gnt       = '0;
        rd_valid  = '0;
        we_sel    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (grant && 32'(gnt_idx) == k) begin
                gnt[k]    = 1'b1;
                we_sel    = we[k];
                mem_addr  = addr[k*ADDR_W +: ADDR_W];
                mem_wdata = wdata[k*DATA_W +: DATA_W];
            end
            if (tag_vld_q && 32'(tag_port_q) == k) begin
                rd_valid[k] = 1'b1;
            end
        end
        mem_cs    = grant;
        mem_wr_en = grant & we_sel;
    end

    // Memory data passes straight through on the return cycle; the register
    // only keeps the last value visible in between.
    assign rd_data = tag_vld_q ? mem_rdata : rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            tag_vld_q  <= 1'b0;
            tag_port_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            tag_vld_q  <= grant & ~we_sel;
            tag_port_q <= gnt_idx;
            if (tag_vld_q) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spram_byte_arbiter.sv
// Directed self-checking bench for spram_byte_arbiter (MAX_BURST = 4).
// A behavioural 1-cycle-latency byte memory sits on the mem_* port; unwritten
// locations read back as addr[7:0] ^ 8'h5A.
module tb_spram_byte_arbiter;

    localparam int NP = 3;
    localparam int AW = 17;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req, lock, we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     gnt, rd_valid;
    logic [DW-1:0]     rd_data;
    logic              mem_cs, mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    spram_byte_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .mem_cs    (mem_cs),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wr_en)
                mem[mem_addr] = mem_wdata;
            else if (mem.exists(mem_addr))
                mem_rdata <= mem[mem_addr];
            else
                mem_rdata <= mem_addr[7:0] ^ 8'h5A;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]           = r;
        lock[p]          = l;
        we[p]            = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    logic [NP-1:0] rr_gnt  [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    logic [NP-1:0] rr_rv   [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
    logic [DW-1:0] rr_rd   [8] = '{8'h00, 8'h4A, 8'h7A, 8'h6A, 8'h4A, 8'h7A, 8'h6A, 8'h6A};
    logic [AW-1:0] rr_addr [6] = '{17'h10, 17'h20, 17'h30, 17'h10, 17'h20, 17'h30};
    logic [NP-1:0] bu_gnt  [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
                                    3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [NP-1:0] id_gnt  [4] = '{3'b000, 3'b000, 3'b000, 3'b010};

    initial begin
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_mem_cs", mem_cs, 0);
        chk("reset_mem_wr_en", mem_wr_en, 0);
        chk("reset_rd_data", rd_data, 0);

        // Three readers, no lock: strict rotation, read return one cycle later
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst = 1'b0;
                set_port(0, 1'b1, 1'b0, 1'b0, 17'h10, 8'h00);
                set_port(1, 1'b1, 1'b0, 1'b0, 17'h20, 8'h00);
                set_port(2, 1'b1, 1'b0, 1'b0, 17'h30, 8'h00);
            end
            if (k == 6) req = '0;
            #1;
            chk("rr_gnt", gnt, rr_gnt[k]);
            chk("rr_rd_valid", rd_valid, rr_rv[k]);
            chk("rr_rd_data", rd_data, rr_rd[k]);
            if (k < 6) chk("rr_mem_addr", mem_addr, rr_addr[k]);
        end

        // Write then read the top byte on consecutive cycles
        @(negedge clk);
        set_port(1, 1'b1, 1'b0, 1'b1, 17'h1FFFF, 8'hA5);
        #1;
        chk("raw_wr_gnt", gnt, 3'b010);
        chk("raw_wr_cs", mem_cs, 1);
        chk("raw_wr_en", mem_wr_en, 1);
        chk("raw_wr_addr", mem_addr, 17'h1FFFF);
        chk("raw_wr_data", mem_wdata, 8'hA5);
        @(negedge clk);
        we[1] = 1'b0;
        #1;
        chk("raw_rd_gnt", gnt, 3'b010);
        chk("raw_rd_wr_en", mem_wr_en, 0);
        chk("raw_rd_addr", mem_addr, 17'h1FFFF);
        chk("raw_no_wr_resp", rd_valid, 0);
        @(negedge clk);
        req[1] = 1'b0;
        #1;
        chk("raw_rd_valid", rd_valid, 3'b010);
        chk("raw_rd_data", rd_data, 8'hA5);
        chk("raw_idle_gnt", gnt, 0);

        // Idle: nothing issued, read data holds
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("idle_mem_cs", mem_cs, 0);
            chk("idle_gnt", gnt, 0);
            chk("idle_rd_valid", rd_valid, 0);
            chk("idle_rd_data", rd_data, 8'hA5);
        end

        // Read granted, reset on the following edge drops the return
        @(negedge clk);
        set_port(1, 1'b1, 1'b0, 1'b0, 17'h00100, 8'h00);
        #1;
        chk("rst_rd_gnt", gnt, 3'b010);
        #2;
        rst = 1'b1;
        @(negedge clk);
        req = '0;
        #1;
        chk("rst_drop_rd_valid", rd_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_rd_data", rd_data, 0);

        // Locked burst on port 0 against port 2: 4 grants, rotate, resume
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                rst = 1'b0;
                set_port(0, 1'b1, 1'b1, 1'b1, 17'h00200, 8'h11);
                set_port(2, 1'b1, 1'b0, 1'b1, 17'h00300, 8'h22);
            end
            if (k == 5) set_port(2, 1'b0, 1'b0, 1'b0, 17'h0, 8'h00);
            #1;
            chk("burst_gnt", gnt, bu_gnt[k]);
            if (k == 4) begin
                chk("burst_rot_addr", mem_addr, 17'h00300);
                chk("burst_rot_wdata", mem_wdata, 8'h22);
            end
        end

        // Owner holds lock with no request: memory idle, then release
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_port(0, 1'b0, 1'b1, 1'b1, 17'h00200, 8'h11);
                set_port(1, 1'b1, 1'b0, 1'b1, 17'h00400, 8'h33);
            end
            if (k == 3) lock[0] = 1'b0;
            #1;
            chk("hold_gnt", gnt, id_gnt[k]);
            chk("hold_mem_cs", mem_cs, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        req = '0; lock = '0;
        #1;
        chk("final_gnt", gnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
